id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port stall  in  1  hold IF/ID and ID/EX state.
REQ-004 SHALL have port flush  in  1  squash instruction entering ID/EX.
REQ-005 SHALL have port in  in  if_id_t  {pc, pcplus4, instr}; instr is synchronous-BRAM data for pc presented one cycle earlier.
REQ-006 SHALL have ports wb_we  in  1, wb_rd  in  5, wb_data  in  32: register-file write port from writeback.
REQ-007 SHALL have port out  out  id_ex_t  {valid, pc, pcplus4, rs1, rs2, rd, rs1_data, rs2_data, imm[31:0], funct3, alu_op[3:0], alu_src_imm, reg_write, mem_read, mem_write, branch, jal, jalr, illegal}.

Function
REQ-008 SHALL register in.pc and in.pcplus4 into pc_q/pcplus4_q plus valid_q each cycle stall=0, aligning them with in.instr; stall=1 holds them.
REQ-009 SHALL decode in.instr combinationally against pc_q/pcplus4_q/valid_q.
REQ-010 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; any other opcode sets illegal=1 with reg_write, mem_read, mem_write, branch, jal, jalr all 0.
REQ-011 SHALL generate imm per I/S/B/U/J format, sign-extended from bit 31; B/J bit 0 = 0; U low 12 bits = 0; R-type imm = 0.
REQ-012 SHALL set alu_op from opcode/funct3/funct7[5]: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB (LUI); SUB only for OP with funct7[5]=1; SRAI via funct7[5] on OP-IMM.
REQ-013 SHALL set rd=0 and reg_write=0 for BRANCH/STORE; rd=0 and reg_write=0 when instr rd field is 0.
REQ-014 SHALL contain 31x32-bit register file (x1..x31), written on clk when wb_we=1 and wb_rd!=0, independent of stall/flush.
REQ-015 SHALL return 0 for any read of x0.
REQ-016 SHALL bypass write-first: read of register r in cycle where wb_we=1, wb_rd=r, r!=0 returns wb_data.
REQ-017 SHALL register decode results into out (ID/EX) on each edge with stall=0, flush=0; out.valid=valid_q.
REQ-018 SHALL, with flush=1, load out with valid=0 and all control bits (reg_write, mem_read, mem_write, branch, jal, jalr, illegal) 0, regardless of stall (flush dominates).
REQ-019 SHALL, with stall=1 and flush=0, hold out unchanged, including rs1_data/rs2_data (stale-operand handling belongs to forwarding unit).
REQ-020 SHALL produce decode-to-out latency of one cycle; instruction fetched at pc appears on out two edges after pc is presented.

Reset
REQ-021 SHALL, with rst=1, clear valid_q, pc_q, pcplus4_q to 0 and out to all-zero (valid=0, control bits 0); rst dominates stall and flush.
REQ-022 SHALL NOT reset register-file contents; regfile writes during rst=1 are suppressed.
REQ-023 SHALL emit out.valid=1 no earlier than the second edge after rst deasserts.

Verification
REQ-024 ADDI x5,x0,-1 (0xFFF00293) at pc=0x10 -> out: valid=1, rd=5, imm=0xFFFFFFFF, alu_op=ADD, alu_src_imm=1, reg_write=1, pc=0x10, pcplus4=0x14.
REQ-025 wb_we=1, wb_rd=3, wb_data=0xDEADBEEF same cycle as decoding ADD x1,x3,x0 -> out.rs1_data=0xDEADBEEF, rs2_data=0; write wb_rd=0 then read x0 -> 0.
REQ-026 BEQ with offset -8 -> imm=0xFFFFFFF8, branch=1, reg_write=0, rd=0; JAL offset +2048 -> imm=0x00000800, jal=1.
REQ-027 stall=1 for 3 cycles mid-stream -> out and pc_q constant; release -> next instruction emerges without loss or duplication; flush=1 with stall=1 -> out.valid=0 next cycle.
REQ-028 opcode 0x7F -> illegal=1, valid=1, all write/memory controls 0; rst=1 mid-stream -> out all-zero next edge, regfile retains prior values.

Source files
------------

// File: rtl/id_stage_if.sv
// Bus bundle for the decode stage: IF/ID payload in, ID/EX payload out,
// pipeline control and the writeback register-file port.
interface id_stage_if;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } id_ex_t;

  logic        stall;
  logic        flush;
  if_id_t      in;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  id_ex_t      out;

  modport master (output stall, flush, in, wb_we, wb_rd, wb_data, input out);
  modport slave  (input stall, flush, in, wb_we, wb_rd, wb_data, output out);

endinterface

// File: rtl/id_stage.sv
// RV32I instruction decode stage: IF/ID pc alignment, combinational decode,
// 31x32 register file with write-first bypass, and the ID/EX pipeline register.
module id_stage (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Arithmetic op from funct3; alt selects SUB (000) or SRA (101).
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // IF/ID state: pc of the instruction currently on in.instr
  logic [31:0] pc_q, pcplus4_q;
  logic        valid_q;
  logic [31:0] rf_q [1:31];

  // Field extraction
  logic [31:0] instr_s;
  logic [6:0]  opcode_s;
  logic [4:0]  rd_fld_s, rs1_s, rs2_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;

  assign instr_s  = bus.in.instr;
  assign opcode_s = instr_s[6:0];
  assign rd_fld_s = instr_s[11:7];
  assign funct3_s = instr_s[14:12];
  assign rs1_s    = instr_s[19:15];
  assign rs2_s    = instr_s[24:20];

  assign imm_i_s = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_u_s = {instr_s[31:12], 12'd0};
  assign imm_j_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

  // Register read with write-first bypass from the writeback port
  logic [31:0] rs1_data_d, rs2_data_d;
  assign rs1_data_d = (rs1_s == 5'd0) ? 32'd0 :
                      (bus.wb_we && (bus.wb_rd == rs1_s)) ? bus.wb_data : rf_q[rs1_s];
  assign rs2_data_d = (rs2_s == 5'd0) ? 32'd0 :
                      (bus.wb_we && (bus.wb_rd == rs2_s)) ? bus.wb_data : rf_q[rs2_s];

  // Decode outputs
  logic [31:0] imm_d;
  logic [3:0]  alu_op_d;
  logic        alu_src_imm_d, writes_rd_s, mem_read_d, mem_write_d;
  logic        branch_d, jal_d, jalr_d, illegal_d, reg_write_d;
  logic [4:0]  rd_d;

  // Opcode decode into immediate, ALU op and control bits
  always_comb begin
    imm_d         = 32'd0;
    alu_op_d      = ALU_ADD;
    alu_src_imm_d = 1'b0;
    writes_rd_s   = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    branch_d      = 1'b0;
    jal_d         = 1'b0;
    jalr_d        = 1'b0;
    illegal_d     = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        imm_d = imm_u_s; alu_op_d = ALU_PASSB; alu_src_imm_d = 1'b1; writes_rd_s = 1'b1;
      end
      OPC_AUIPC: begin
        imm_d = imm_u_s; alu_src_imm_d = 1'b1; writes_rd_s = 1'b1;
      end
      OPC_JAL: begin
        imm_d = imm_j_s; jal_d = 1'b1; writes_rd_s = 1'b1;
      end
      OPC_JALR: begin
        imm_d = imm_i_s; jalr_d = 1'b1; alu_src_imm_d = 1'b1; writes_rd_s = 1'b1;
      end
      OPC_BRANCH: begin
        imm_d    = imm_b_s;
        branch_d = 1'b1;
        case (funct3_s[2:1])
          2'b10:   alu_op_d = ALU_SLT;
          2'b11:   alu_op_d = ALU_SLTU;
          default: alu_op_d = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        imm_d = imm_i_s; mem_read_d = 1'b1; alu_src_imm_d = 1'b1; writes_rd_s = 1'b1;
      end
      OPC_STORE: begin
        imm_d = imm_s_s; mem_write_d = 1'b1; alu_src_imm_d = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_d         = imm_i_s;
        alu_src_imm_d = 1'b1;
        writes_rd_s   = 1'b1;
        // only the shift-right encoding uses funct7[5] for immediates
        alu_op_d      = alu_from_f3(funct3_s, instr_s[30] && (funct3_s == 3'b101));
      end
      OPC_OP: begin
        writes_rd_s = 1'b1;
        alu_op_d    = alu_from_f3(funct3_s, instr_s[30]);
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase
  end

  // Writes to x0 are dropped at decode so downstream hazard logic never sees rd=0 writes
  assign reg_write_d = writes_rd_s && (rd_fld_s != 5'd0);
  assign rd_d        = reg_write_d ? rd_fld_s : 5'd0;

  // IF/ID register: align pc with the synchronous-BRAM instruction word
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= 32'd0;
      pcplus4_q <= 32'd0;
      valid_q   <= 1'b0;
    end else if (!bus.stall) begin
      pc_q      <= bus.in.pc;
      pcplus4_q <= bus.in.pcplus4;
      valid_q   <= 1'b1;
    end
  end

  // Register file write port; contents survive reset, writes during reset are dropped
  always_ff @(posedge clk) begin
    if (!rst && bus.wb_we && (bus.wb_rd != 5'd0)) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  // ID/EX register: reset dominates flush, flush dominates stall
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out <= '0;
    end else if (bus.flush) begin
      bus.out <= '0;
    end else if (!bus.stall) begin
      bus.out.valid       <= valid_q;
      bus.out.pc          <= pc_q;
      bus.out.pcplus4     <= pcplus4_q;
      bus.out.rs1         <= rs1_s;
      bus.out.rs2         <= rs2_s;
      bus.out.rd          <= rd_d;
      bus.out.rs1_data    <= rs1_data_d;
      bus.out.rs2_data    <= rs2_data_d;
      bus.out.imm         <= imm_d;
      bus.out.funct3      <= funct3_s;
      bus.out.alu_op      <= alu_op_d;
      bus.out.alu_src_imm <= alu_src_imm_d;
      bus.out.reg_write   <= reg_write_d;
      bus.out.mem_read    <= mem_read_d;
      bus.out.mem_write   <= mem_write_d;
      bus.out.branch      <= branch_d;
      bus.out.jal         <= jal_d;
      bus.out.jalr        <= jalr_d;
      bus.out.illegal     <= illegal_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus a randomized
// stream checked against an instruction-level reference model.
module tb_id_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } exp_t;

  localparam logic [3:0] A_ADD = 4'd0;
  localparam logic [3:0] A_SUB = 4'd1;
  localparam logic [3:0] A_SLT = 4'd3;
  localparam logic [3:0] A_SLTU = 4'd4;
  localparam logic [3:0] A_PASSB = 4'd10;
  // ALU op per funct3 (nibble i = funct3 i); the alternate form is the next code
  localparam logic [31:0] F3_TBL = 32'h98654320;

  logic clk = 1'b0;
  logic rst;
  id_stage_if bus ();

  id_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        m_out, act, snap;
  logic        m_valid, m_ctrl_only;
  logic [31:0] m_pc, m_pc4;
  logic [31:0] ref_rf [0:31];
  logic [31:0] imem [0:255];
  logic [31:0] fpc, last_pc;

  function automatic logic [7:0] ctrl_of(input exp_t e);
    return {e.valid, e.reg_write, e.mem_read, e.mem_write, e.branch, e.jal, e.jalr, e.illegal};
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  op;
    logic [6:0]  ops [9];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    w = $urandom;
    if ($urandom_range(0, 9) == 0) begin
      op = 7'($urandom);
      while (is_legal(op)) op = 7'($urandom);
    end else begin
      op = ops[$urandom_range(0, 8)];
    end
    if (op == 7'h63 && w[14:13] == 2'b01) w[13] = 1'b0;
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    w[6:0] = op;
    return w;
  endfunction

  // Instruction-level meaning of one RV32I word
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4,
                                      input logic v, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [31:0] i_imm, s_imm, u_imm, b_imm, j_imm, tbl;
    logic [2:0]  f3;
    logic        wr;
    tbl   = F3_TBL;
    f3    = ins[14:12];
    i_imm = $unsigned($signed(ins) >>> 20);
    s_imm = (i_imm & 32'hFFFFFFE0) | {27'd0, ins[11:7]};
    u_imm = ins & 32'hFFFFF000;
    b_imm = ($unsigned($signed(ins) >>> 19) & 32'hFFFFF000) | ({31'd0, ins[7]} << 11)
          | ({26'd0, ins[30:25]} << 5) | ({28'd0, ins[11:8]} << 1);
    j_imm = ($unsigned($signed(ins) >>> 11) & 32'hFFF00000) | (ins & 32'h000FF000)
          | ({31'd0, ins[20]} << 11) | ({22'd0, ins[30:21]} << 1);
    e = '0;
    e.valid = v; e.pc = pc; e.pcplus4 = pc4;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rs1_data = r1; e.rs2_data = r2;
    e.funct3 = f3; e.alu_op = A_ADD;
    wr = 1'b0;
    case (ins[6:0])
      7'h37: begin e.imm = u_imm; e.alu_op = A_PASSB; e.alu_src_imm = 1'b1; wr = 1'b1; end
      7'h17: begin e.imm = u_imm; e.alu_src_imm = 1'b1; wr = 1'b1; end
      7'h6F: begin e.imm = j_imm; e.jal = 1'b1; wr = 1'b1; end
      7'h67: begin e.imm = i_imm; e.jalr = 1'b1; e.alu_src_imm = 1'b1; wr = 1'b1; end
      7'h63: begin
        e.imm = b_imm; e.branch = 1'b1;
        e.alu_op = (f3 == 3'd4 || f3 == 3'd5) ? A_SLT : (f3 >= 3'd6) ? A_SLTU : A_SUB;
      end
      7'h03: begin e.imm = i_imm; e.mem_read = 1'b1; e.alu_src_imm = 1'b1; wr = 1'b1; end
      7'h23: begin e.imm = s_imm; e.mem_write = 1'b1; e.alu_src_imm = 1'b1; end
      7'h13: begin
        e.imm = i_imm; e.alu_src_imm = 1'b1; wr = 1'b1;
        e.alu_op = tbl[f3*4 +: 4] + {3'd0, (f3 == 3'd5) && ins[30]};
      end
      7'h33: begin
        wr = 1'b1;
        e.alu_op = tbl[f3*4 +: 4] + {3'd0, (f3 == 3'd0 || f3 == 3'd5) && ins[30]};
      end
      default: e.illegal = 1'b1;
    endcase
    if (wr && ins[11:7] != 5'd0) begin
      e.reg_write = 1'b1;
      e.rd = ins[11:7];
    end
    return e;
  endfunction

  // One clock: drive inputs, advance the reference model, sample out after the edge
  task automatic tick(input logic r, input logic s, input logic f, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wd);
    logic [31:0] ins, a, b;
    exp_t e;
    ins = imem[last_pc[9:2]];
    rst = r; bus.stall = s; bus.flush = f;
    bus.wb_we = we; bus.wb_rd = wrd; bus.wb_data = wd;
    bus.in.pc = fpc; bus.in.pcplus4 = fpc + 32'd4; bus.in.instr = ins;
    a = (ins[19:15] == 5'd0) ? 32'd0 : (we && wrd == ins[19:15]) ? wd : ref_rf[ins[19:15]];
    b = (ins[24:20] == 5'd0) ? 32'd0 : (we && wrd == ins[24:20]) ? wd : ref_rf[ins[24:20]];
    e = ref_decode(ins, m_pc, m_pc4, m_valid, a, b);
    if (r) begin
      m_out = '0; m_ctrl_only = 1'b0;
      m_pc = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      fpc = 32'd0; last_pc = 32'd0;
    end else begin
      if (f) begin
        m_out = '0; m_ctrl_only = 1'b1;
      end else if (!s) begin
        m_out = e; m_ctrl_only = 1'b0;
      end
      if (!s) begin
        m_pc = fpc; m_pc4 = fpc + 32'd4; m_valid = 1'b1;
        last_pc = fpc; fpc = (fpc + 32'd4) & 32'h3FC;
      end
      if (we && wrd != 5'd0) ref_rf[wrd] = wd;
    end
    @(posedge clk);
    #1;
    act = bus.out;
  endtask

  task automatic init_regs();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 1; i < 32; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 5'(i), $urandom);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
      checks++;
      if (act !== m_out || act !== '0) begin
        errors++; $display("FAIL reset_out act=%h exp=%h", act, m_out);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (act.valid !== 1'b0) begin errors++; $display("FAIL reset_valid_edge1 act=%b exp=0", act.valid); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (act !== m_out || act.valid !== 1'b1) begin
      errors++; $display("FAIL reset_valid_edge2 act=%h exp=%h", act, m_out);
    end
  endtask

  task automatic test_addi();
    imem[4] = 32'hFFF00293;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      checks++;
      if (act !== m_out) begin errors++; $display("FAIL addi_stream act=%h exp=%h", act, m_out); end
    end
    checks++;
    if ({act.valid, act.rd, act.imm, act.alu_op, act.alu_src_imm, act.reg_write, act.pc, act.pcplus4}
        !== {1'b1, 5'd5, 32'hFFFFFFFF, A_ADD, 1'b1, 1'b1, 32'h10, 32'h14}) begin
      errors++;
      $display("FAIL addi_fields act v=%b rd=%0d imm=%h alu=%0d si=%b rw=%b pc=%h pc4=%h exp 1 5 ffffffff 0 1 1 10 14",
               act.valid, act.rd, act.imm, act.alu_op, act.alu_src_imm, act.reg_write, act.pc, act.pcplus4);
    end
  endtask

  task automatic test_bypass();
    imem[0] = 32'h000180B3;  // add x1,x3,x0
    imem[1] = 32'h00000133;  // add x2,x0,x0
    imem[2] = 32'h00018133;  // add x2,x3,x0
    tick(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h12345678);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
    checks++;
    if (act.rs1_data !== 32'hDEADBEEF || act.rs2_data !== 32'd0 || act !== m_out) begin
      errors++; $display("FAIL bypass_rs1 act rs1=%h rs2=%h exp rs1=deadbeef rs2=0", act.rs1_data, act.rs2_data);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    checks++;
    if (act.rs1_data !== 32'd0 || act.rs2_data !== 32'd0) begin
      errors++; $display("FAIL bypass_x0 act rs1=%h rs2=%h exp 0 0", act.rs1_data, act.rs2_data);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (act.rs1_data !== 32'hDEADBEEF || act !== m_out) begin
      errors++; $display("FAIL regfile_x3 act=%h exp=deadbeef", act.rs1_data);
    end
  endtask

  task automatic test_branch_jal();
    imem[0] = 32'hFE000CE3;  // beq x0,x0,-8
    imem[1] = 32'h001000EF;  // jal x1,+2048
    tick(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if ({act.imm, act.branch, act.reg_write, act.rd, act.valid} !== {32'hFFFFFFF8, 1'b1, 1'b0, 5'd0, 1'b1}) begin
      errors++; $display("FAIL beq act imm=%h br=%b rw=%b rd=%0d v=%b exp fffffff8 1 0 0 1",
                         act.imm, act.branch, act.reg_write, act.rd, act.valid);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if ({act.imm, act.jal, act.reg_write, act.rd} !== {32'h00000800, 1'b1, 1'b1, 5'd1} || act !== m_out) begin
      errors++; $display("FAIL jal act imm=%h jal=%b rw=%b rd=%0d exp 00000800 1 1 1",
                         act.imm, act.jal, act.reg_write, act.rd);
    end
  endtask

  task automatic test_stall_flush();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    snap = act;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      checks++;
      if (act !== snap) begin errors++; $display("FAIL stall_hold%0d act=%h exp=%h", i, act, snap); end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (act.pc !== snap.pc + 32'd4 || act !== m_out) begin
      errors++; $display("FAIL stall_release act pc=%h exp pc=%h", act.pc, snap.pc + 32'd4);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    checks++;
    if (ctrl_of(act) !== 8'd0) begin errors++; $display("FAIL flush_stall act ctrl=%b exp=00000000", ctrl_of(act)); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (act.pc !== snap.pc + 32'd12 || act.valid !== 1'b1 || act !== m_out) begin
      errors++; $display("FAIL flush_resume act pc=%h v=%b exp pc=%h v=1", act.pc, act.valid, snap.pc + 32'd12);
    end
  endtask

  task automatic test_illegal_rst();
    imem[0] = 32'h1234507F;  // opcode 0x7F
    imem[1] = 32'h000380B3;  // add x1,x7,x0
    tick(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hCAFEF00D);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (ctrl_of(act) !== 8'b1000_0001 || act !== m_out) begin
      errors++; $display("FAIL illegal act ctrl=%b exp=10000001", ctrl_of(act));
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'hBAD0BAD0);
    checks++;
    if (act !== '0) begin errors++; $display("FAIL rst_mid act=%h exp=0", act); end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (act.rs1_data !== 32'hCAFEF00D || act !== m_out) begin
      errors++; $display("FAIL rf_retain act=%h exp=cafef00d", act.rs1_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) imem[i] = gen_instr();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int n = 0; n < 2000; n++) begin
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           1'($urandom), 5'($urandom), $urandom);
      checks++;
      if (m_ctrl_only ? (ctrl_of(act) !== ctrl_of(m_out)) : (act !== m_out)) begin
        errors++; $display("FAIL random_%0d act=%h exp=%h", n, act, m_out);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    bus.in = '0;
    m_out = '0; m_ctrl_only = 1'b0; m_valid = 1'b0; m_pc = 32'd0; m_pc4 = 32'd0;
    fpc = 32'd0; last_pc = 32'd0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    for (int i = 0; i < 256; i++) imem[i] = gen_instr();
    init_regs();
    test_reset();
    test_addi();
    test_bypass();
    test_branch_jal();
    test_stall_flush();
    test_illegal_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
